// File: rtl/synth_pkg.sv
// Shared synth definitions: envelope state encoding and audio constants.
package synth_pkg;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;

  localparam logic [11:0] AUDIO_MID = 12'd2048;
  localparam logic [7:0]  ENV_MAX   = 8'd255;
endpackage

// File: rtl/adsr_envelope_if.sv
// Channel-side envelope signals: gate and oscillator sample in, scaled sample and level out.
interface adsr_envelope_if;
  logic        gate;
  logic [11:0] sample_in;
  logic [11:0] sample_out;
  logic [7:0]  level;
  logic        active;

  modport master (output gate, sample_in, input sample_out, level, active);
  modport slave  (input gate, sample_in, output sample_out, level, active);
endinterface

// File: rtl/env_tick_gen.sv
// Free-running rate divider: one-cycle tick every DIVIDE+1 clocks.
module env_tick_gen #(
  parameter int DIVIDE = 11999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (DIVIDE > 0) ? $clog2(DIVIDE + 1) : 1;

  logic [W-1:0] count_q, count_d;

  assign tick = (count_q == W'(DIVIDE));

  always_comb begin
    count_d = tick ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/adsr_envelope.sv
// Per-channel ADSR envelope: gate-driven level FSM and sample scaler about the audio midpoint.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int TICK_DIVIDE   = 11999,
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 2,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 4
) (
  input logic            clk,
  input logic            rst,
  adsr_envelope_if.slave env
);
  localparam logic [8:0] ATK9 = 9'(ATTACK_STEP);
  localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
  localparam logic [8:0] REL9 = 9'(RELEASE_STEP);
  localparam logic [7:0] SUS8 = 8'(SUSTAIN_LEVEL);

  env_state_t state_q, state_d;
  logic [7:0]  level_q, level_d;
  logic        active_q, gate_q;
  logic [11:0] sample_out_q;
  logic        tick, rise, fall;
  logic [8:0]  sum, dec, rel;

  env_tick_gen #(.DIVIDE(TICK_DIVIDE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rise = env.gate & ~gate_q;
  assign fall = ~env.gate & (state_q inside {ATTACK, DECAY, SUSTAIN});

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    sum     = {1'b0, level_q} + ATK9;
    dec     = {1'b0, level_q} - DEC9;
    rel     = {1'b0, level_q} - REL9;
    // Edges take priority over the tick; a retrigger keeps the current level.
    if (rise) begin
      state_d = ATTACK;
    end else if (fall) begin
      state_d = RELEASE;
    end else if (tick) begin
      unique case (state_q)
        ATTACK: begin
          if (sum >= 9'd255) begin
            level_d = ENV_MAX;
            state_d = DECAY;
          end else begin
            level_d = sum[7:0];
          end
        end
        DECAY: begin
          if (dec[8] || (dec <= {1'b0, SUS8})) begin
            level_d = SUS8;
            state_d = SUSTAIN;
          end else begin
            level_d = dec[7:0];
          end
        end
        RELEASE: begin
          if (rel[8] || (rel == 9'd0)) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = rel[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  logic signed [12:0] diff;
  logic signed [8:0]  lvl_s;
  logic signed [21:0] prod, out_full;

  always_comb begin
    diff     = $signed({1'b0, env.sample_in}) - 13'sd2048;
    lvl_s    = $signed({1'b0, level_q});
    prod     = 22'(diff) * 22'(lvl_s);
    out_full = 22'sd2048 + (prod >>> 8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= '0;
      active_q     <= 1'b0;
      gate_q       <= 1'b0;
      sample_out_q <= AUDIO_MID;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      active_q     <= (state_d != IDLE);
      gate_q       <= env.gate;
      sample_out_q <= out_full[11:0];
    end
  end

  // |d*level/256| never exceeds 2048, so the midpoint offset cannot leave 12 bits.
  a_out_range: assert property (@(posedge clk) disable iff (rst)
    (out_full >= 22'sd0) && (out_full <= 22'sd4095));

  assign env.level      = level_q;
  assign env.active     = active_q;
  assign env.sample_out = sample_out_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: three sustain variants driven in lockstep, checked every cycle against an arithmetic model.
module tb_adsr_envelope;
  localparam int TD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adsr_envelope_if e_a ();
  adsr_envelope_if e_b ();
  adsr_envelope_if e_c ();

  adsr_envelope #(.TICK_DIVIDE(TD), .SUSTAIN_LEVEL(160)) u_a (.clk(clk), .rst(rst), .env(e_a));
  adsr_envelope #(.TICK_DIVIDE(TD), .SUSTAIN_LEVEL(128)) u_b (.clk(clk), .rst(rst), .env(e_b));
  adsr_envelope #(.TICK_DIVIDE(TD), .SUSTAIN_LEVEL(255)) u_c (.clk(clk), .rst(rst), .env(e_c));

  int n_chk = 0;
  int n_pass = 0;

  bit    cur_rst, cur_gate;
  int    cur_samp;
  int    m_cnt = 0;
  bit    m_gq = 0;
  string m_ph [3] = '{"idle", "idle", "idle"};
  int    m_lvl [3] = '{0, 0, 0};
  int    m_so [3] = '{2048, 2048, 2048};

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
  endtask

  function automatic int sus_of(input int k);
    return (k == 0) ? 160 : ((k == 1) ? 128 : 255);
  endfunction

  // 2048 + floor((s-2048)*lvl/256), written as explicit floor division.
  function automatic int scale(input int s, input int lvl);
    int p;
    p = (s - 2048) * lvl;
    return 2048 + ((p >= 0) ? (p / 256) : -((-p + 255) / 256));
  endfunction

  task automatic model_edge();
    bit tick, rise;
    int nl;
    if (cur_rst) begin
      m_cnt = 0;
      m_gq  = 0;
      for (int k = 0; k < 3; k++) begin
        m_ph[k] = "idle"; m_lvl[k] = 0; m_so[k] = 2048;
      end
      return;
    end
    tick  = (m_cnt == TD);
    rise  = cur_gate && !m_gq;
    m_cnt = tick ? 0 : m_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      m_so[k] = scale(cur_samp, m_lvl[k]);
      if (rise) m_ph[k] = "attack";
      else if (!cur_gate && (m_ph[k] == "attack" || m_ph[k] == "decay" || m_ph[k] == "sustain"))
        m_ph[k] = "release";
      else if (tick) begin
        if (m_ph[k] == "attack") begin
          nl = m_lvl[k] + 8; if (nl > 255) nl = 255;
          m_lvl[k] = nl; if (nl == 255) m_ph[k] = "decay";
        end else if (m_ph[k] == "decay") begin
          nl = m_lvl[k] - 2; if (nl < sus_of(k)) nl = sus_of(k);
          m_lvl[k] = nl; if (nl == sus_of(k)) m_ph[k] = "sustain";
        end else if (m_ph[k] == "release") begin
          nl = m_lvl[k] - 4; if (nl < 0) nl = 0;
          m_lvl[k] = nl; if (nl == 0) m_ph[k] = "idle";
        end
      end
    end
    m_gq = cur_gate;
  endtask

  task automatic drive(input bit r, input bit g, input int s);
    cur_rst = r; cur_gate = g; cur_samp = s;
    rst = r;
    e_a.gate = g; e_b.gate = g; e_c.gate = g;
    e_a.sample_in = 12'(s); e_b.sample_in = 12'(s); e_c.sample_in = 12'(s);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("a.level", int'(e_a.level), m_lvl[0]);
    chk("b.level", int'(e_b.level), m_lvl[1]);
    chk("c.level", int'(e_c.level), m_lvl[2]);
    chk("a.active", int'(e_a.active), int'(m_ph[0] != "idle"));
    chk("b.active", int'(e_b.active), int'(m_ph[1] != "idle"));
    chk("c.active", int'(e_c.active), int'(m_ph[2] != "idle"));
    chk("a.sample_out", int'(e_a.sample_out), m_so[0]);
    chk("b.sample_out", int'(e_b.sample_out), m_so[1]);
    chk("c.sample_out", int'(e_c.sample_out), m_so[2]);
  endtask

  task automatic run(input bit g, input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, g, $urandom_range(0, 4095));
      cycle();
    end
  endtask

  function automatic bit all_in(input string ph);
    return (m_ph[0] == ph) && (m_ph[1] == ph) && (m_ph[2] == ph);
  endfunction

  initial begin
    int saved, guard;

    // Reset release with a large input: output must sit at the midpoint.
    drive(1, 0, 4000);
    cycle(); cycle();
    chk("rst_level", int'(e_a.level), 0);
    chk("rst_active", int'(e_a.active), 0);
    chk("rst_sample_out", int'(e_a.sample_out), 2048);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 4000);
      cycle();
    end
    chk("idle_sample_out", int'(e_a.sample_out), 2048);

    // Attack, decay, sustain.
    drive(0, 1, 3000);
    cycle();
    chk("attack_active", int'(e_a.active), 1);
    guard = 0;
    while (!all_in("sustain") && guard < 1000) begin
      run(1, 1);
      guard++;
    end
    if (!all_in("sustain")) chk("sustain_timeout", 0, 1);
    run(1, 10);
    chk("a_sustain", int'(e_a.level), 160);
    chk("b_sustain", int'(e_b.level), 128);
    chk("c_sustain", int'(e_c.level), 255);

    // Scaling at fixed levels, one cycle latency.
    drive(0, 1, 3048); cycle(); chk("scale_3048_l128", int'(e_b.sample_out), 2548);
    drive(0, 1, 1048); cycle(); chk("scale_1048_l128", int'(e_b.sample_out), 1548);
    drive(0, 1, 2048); cycle(); chk("scale_2048_l128", int'(e_b.sample_out), 2048);
    drive(0, 1, 4095); cycle(); chk("scale_4095_l255", int'(e_c.sample_out), 4087);
    drive(0, 1, 0);    cycle(); chk("scale_0_l255", int'(e_c.sample_out), 8);

    // Release to idle.
    guard = 0;
    while (!all_in("idle") && guard < 1000) begin
      run(0, 1);
      guard++;
    end
    if (!all_in("idle")) chk("release_timeout", 0, 1);
    chk("release_active", int'(e_a.active), 0);
    drive(0, 0, 4095); cycle(); chk("scale_4095_l0", int'(e_a.sample_out), 2048);
    drive(0, 0, 0);    cycle(); chk("scale_0_l0", int'(e_a.sample_out), 2048);

    // Retrigger: fall in decay near 200, rise in release near 180 on a tick edge.
    guard = 0;
    while (!(m_ph[0] == "decay" && m_lvl[0] <= 201) && guard < 1000) begin
      run(1, 1);
      guard++;
    end
    if (m_ph[0] != "decay") chk("retrig_decay_timeout", 0, 1);
    guard = 0;
    while (!(m_ph[0] == "release" && m_lvl[0] <= 181 && m_cnt == TD) && guard < 1000) begin
      run(0, 1);
      guard++;
    end
    if (m_ph[0] != "release") chk("retrig_release_timeout", 0, 1);
    saved = m_lvl[0];
    run(1, 1);
    chk("retrig_no_step", int'(e_a.level), saved);
    chk("retrig_active", int'(e_a.active), 1);
    run(1, 4);
    chk("retrig_first_step", int'(e_a.level), saved + 8);

    // Reset mid-attack with gate still high.
    run(1, 3);
    drive(1, 1, 3500);
    cycle();
    chk("midrst_level", int'(e_a.level), 0);
    chk("midrst_active", int'(e_a.active), 0);
    chk("midrst_sample_out", int'(e_a.sample_out), 2048);

    // Random gate segments with occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      bit g;
      int len;
      g   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 200);
      for (int i = 0; i < len; i++) begin
        drive(($urandom_range(0, 199) == 0), g, $urandom_range(0, 4095));
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-channel ADSR amplitude envelope, placed between a channel oscillator's 12-bit sample and the channel mixer input.
- Converts the channel's gate (its channel_ena bit) into an 8-bit level.
- Scales the oscillator sample about the audio midpoint, so notes fade in and out instead of clicking on and off.
- One instance per channel; the synth top instantiates NUM_CHANNELS of them.

Parameters:
- TICK_DIVIDE, 11999: an envelope tick fires every TICK_DIVIDE+1 clocks (1 kHz at 12 MHz).
- ATTACK_STEP, 8: level increment per tick in ATTACK.
- DECAY_STEP, 2: level decrement per tick in DECAY.
- SUSTAIN_LEVEL, 160: level held in SUSTAIN, range 0..255.
- RELEASE_STEP, 4: level decrement per tick in RELEASE.

Ports:
- clk  in  1  system clock. One clock domain only.
- rst  in  1  reset, synchronous, active-high.
- gate  in  1  note on (high) / note off (low). Already synchronous to clk.
- sample_in  in  12  unsigned oscillator sample, midpoint 2048.
- sample_out  out  12  scaled sample, unsigned, midpoint 2048.
- level  out  8  current envelope level.
- active  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - state IDLE, level 0, active 0, sample_out 2048.
  - Tick counter 0, registered previous gate (gate_q) 0.
- Tick counter:
  - Free-running 0..TICK_DIVIDE, wraps to 0.
  - tick = (count == TICK_DIVIDE).
  - Gate activity does not reset it.
- Events, evaluated each cycle:
  - rise = gate & ~gate_q.
  - fall = ~gate & (state in ATTACK, DECAY, SUSTAIN).
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Transitions, in priority order:
  1. rise: go to ATTACK from any state. Level is not cleared (legato retrigger). Any tick this cycle is ignored.
  2. fall: go to RELEASE. Any tick this cycle is ignored.
  3. On a tick, by state:
     - ATTACK: level = min(level+ATTACK_STEP, 255). When the result is 255, go to DECAY.
     - DECAY: level = max(level−DECAY_STEP, SUSTAIN_LEVEL). When the result equals SUSTAIN_LEVEL, go to SUSTAIN.
     - SUSTAIN: level is held.
     - RELEASE: level = max(level−RELEASE_STEP, 0). When the result is 0, go to IDLE.
     - IDLE: level is held at 0.
  4. Otherwise: hold state and level.
- Gate held high through IDLE is not a rise. Entering ATTACK requires a fresh 0→1 edge.
- Arithmetic:
  - All step arithmetic uses a 9-bit intermediate, then saturates. No wrap-around.
  - If SUSTAIN_LEVEL ≥ 255, DECAY exits to SUSTAIN on its first tick.
- Scaling:
  - d = signed(sample_in) − 2048, 13-bit.
  - p = d × level, 21-bit signed.
  - sample_out = 2048 + (p >>> 8), arithmetic shift, floor.
  - The result is always within 0..4095; no clipping logic is needed, and an assertion checks this.
- Latency:
  - sample_out is registered. sample_out[n+1] = f(sample_in[n], level[n]).
  - level and active are registered and update the cycle after the triggering event.
- Reset mid-note forces the reset values on the next edge, regardless of gate.
- active is a registered decode of state (state ≠ IDLE).

Decomposition:
- synth_pkg holds the shared definitions:
  - env_state_t enum {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}.
  - AUDIO_MID = 12'd2048.
  - ENV_MAX = 8'd255.
- One sub-module, env_tick_gen: parameter DIVIDE; inputs clk, rst; output tick. It is reusable by other rate-based blocks.
- The FSM, level arithmetic and scaler stay in adsr_envelope.

Test Plan:
All scenarios use TICK_DIVIDE=3, so one tick every 4 clocks.
- Reset release:
  - Stimulus: rst for 2 clocks, gate=0, sample_in=4000.
  - Response: sample_out=2048, level=0, active=0, indefinitely.
- Attack and decay:
  - Stimulus: gate rises and stays high.
  - Response:
    - Next cycle: ATTACK, active=1.
    - level rises 8 per tick and reaches 255 on the 32nd tick, then DECAY.
    - level falls 2 per tick and reaches 160 on the 48th DECAY tick, then SUSTAIN.
    - level then holds at 160.
- Release:
  - Stimulus: gate falls while in SUSTAIN.
  - Response:
    - RELEASE next cycle.
    - level falls 4 per tick and reaches 0 after 40 ticks.
    - Then IDLE and active=0.
- Retrigger:
  - Stimulus: gate falls in DECAY at level 200, then rises again during RELEASE at level 180.
  - Response:
    - ATTACK resumes from 180 (not 0).
    - 180→188 on the next tick.
    - A rise coinciding with a tick causes no level step that cycle.
- Scaling with level forced to 128 (reach it with SUSTAIN_LEVEL=128):
  - sample_in=3048 → sample_out=2548.
  - sample_in=1048 → sample_out=1548.
  - sample_in=2048 → sample_out=2048.
  - Each result appears one cycle later.
- Scaling extremes:
  - level=255, sample_in=4095 → 4087; sample_in=0 → 8.
  - level=0 → 2048 for any input.
  - Reset asserted mid-ATTACK → IDLE, level=0, sample_out=2048 on the next edge.
